// File: rtl/demux1_2_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : demux1_2_if                                                   |
// | Brief    : Handshake bundle for the 1-to-2 demultiplexer (in, A, B).     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface demux1_2_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;

   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] a_data;

   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] b_data;

   // Producer and both consumers as seen from outside the demux.
   modport master (
      output in_valid, in_data, in_sel, a_ready, b_ready,
      input  in_ready, a_valid, a_data, b_valid, b_data
   );

   // The demux itself.
   modport slave (
      input  in_valid, in_data, in_sel, a_ready, b_ready,
      output in_ready, a_valid, a_data, b_valid, b_data
   );
endinterface
`default_nettype wire

// File: rtl/demux1_2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : demux1_2 (with helper demux1_2_fifo)                          |
// | Brief    : Valid/ready 1-to-2 demux with an independent FIFO per output. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

module demux1_2_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [PW-1:0] c_PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] c_CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == c_CNT_FULL);
   assign o_empty   = (r_count == '0);
   assign o_head    = r_mem[r_rptr];

   // A full FIFO refuses a push even when it pops in the same cycle.
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= r_wptr + c_PTR_ONE;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + c_PTR_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module demux1_2 #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   demux1_2_if.slave  bus
);
   logic w_full_a;
   logic w_full_b;
   logic w_empty_a;
   logic w_empty_b;
   logic w_accept;
   logic w_push_a;
   logic w_push_b;
   logic w_pop_a;
   logic w_pop_b;

   // Depends only on in_sel and registered occupancy, never on a/b_ready.
   assign bus.in_ready = rst_n && (bus.in_sel ? !w_full_b : !w_full_a);

   assign w_accept    = bus.in_valid && bus.in_ready;
   assign w_push_a    = w_accept && !bus.in_sel;
   assign w_push_b    = w_accept &&  bus.in_sel;

   assign bus.a_valid = !w_empty_a;
   assign bus.b_valid = !w_empty_b;
   assign w_pop_a     = bus.a_valid && bus.a_ready;
   assign w_pop_b     = bus.b_valid && bus.b_ready;

   demux1_2_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push_a),
      .i_data  (bus.in_data),
      .i_pop   (w_pop_a),
      .o_full  (w_full_a),
      .o_empty (w_empty_a),
      .o_head  (bus.a_data)
   );

   demux1_2_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push_b),
      .i_data  (bus.in_data),
      .i_pop   (w_pop_b),
      .o_full  (w_full_b),
      .o_empty (w_empty_b),
      .o_head  (bus.b_data)
   );
endmodule
`default_nettype wire

// File: tb/tb_demux1_2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_demux1_2                                                   |
// | Brief    : Directed + random scoreboard bench for demux1_2.              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_demux1_2;
   localparam int WIDTH = 32;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] qa [$];
   logic [31:0] qb [$];

   demux1_2_if #(.WIDTH(WIDTH)) bus ();

   demux1_2 #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, check against the queue model before the edge,
   // then update the model with whatever transfers the edge will perform.
   task automatic drive(input logic v, input logic s, input logic [31:0] d,
                        input logic ar, input logic br, output logic acc);
      logic exp_ir;
      bus.in_valid = v;
      bus.in_sel   = s;
      bus.in_data  = d;
      bus.a_ready  = ar;
      bus.b_ready  = br;
      @(negedge clk);
      exp_ir = rst_n && (s ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ir});
      chk("a_valid", {31'd0, bus.a_valid}, {31'd0, qa.size() != 0});
      chk("b_valid", {31'd0, bus.b_valid}, {31'd0, qb.size() != 0});
      if (bus.a_valid && ar && qa.size() != 0) begin
         chk("a_data", bus.a_data, qa[0]);
         void'(qa.pop_front());
      end
      if (bus.b_valid && br && qb.size() != 0) begin
         chk("b_data", bus.b_data, qb[0]);
         void'(qb.pop_front());
      end
      acc = v && bus.in_ready;
      if (acc) begin
         if (s) qb.push_back(d);
         else   qa.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic acc;
      logic [31:0] d;
      logic s;
      int guard;

      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sel   = 1'b0;
      bus.in_data  = '0;
      bus.a_ready  = 1'b1;
      bus.b_ready  = 1'b1;

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
      chk("rst_a_data", bus.a_data, 32'h0);
      chk("rst_b_data", bus.b_data, 32'h0);
      rst_n = 1'b1;
      bus.in_sel = 1'b1;
      #1;
      chk("rel_in_ready_b", {31'd0, bus.in_ready}, 32'd1);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

      // Single routing.
      drive(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, acc);
      chk("route_a_acc", {31'd0, acc}, 32'd1);
      chk("route_a_data", bus.a_data, 32'hDEADBEEF);
      drive(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, acc);
      chk("route_b_acc", {31'd0, acc}, 32'd1);
      chk("route_b_data", bus.b_data, 32'h12345678);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

      // Fill A and check back-pressure is per channel.
      drive(1'b1, 1'b0, 32'h1, 1'b0, 1'b1, acc);
      chk("fill_1", {31'd0, acc}, 32'd1);
      drive(1'b1, 1'b0, 32'h2, 1'b0, 1'b1, acc);
      chk("fill_2", {31'd0, acc}, 32'd1);
      drive(1'b1, 1'b0, 32'h3, 1'b0, 1'b1, acc);
      chk("fill_3_blocked", {31'd0, acc}, 32'd0);
      drive(1'b1, 1'b1, 32'h9, 1'b0, 1'b1, acc);
      chk("switch_b_acc", {31'd0, acc}, 32'd1);
      drive(1'b1, 1'b0, 32'h3, 1'b1, 1'b1, acc);
      chk("pop_full_no_push", {31'd0, acc}, 32'd0);
      drive(1'b1, 1'b0, 32'h3, 1'b1, 1'b1, acc);
      chk("push_after_pop", {31'd0, acc}, 32'd1);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

      // Simultaneous push and pop on a one-entry FIFO.
      drive(1'b1, 1'b0, 32'h77, 1'b0, 1'b1, acc);
      drive(1'b1, 1'b0, 32'h55, 1'b1, 1'b1, acc);
      chk("pushpop_acc", {31'd0, acc}, 32'd1);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

      // Random streaming with random consumer stalls.
      guard = 0;
      for (int i = 0; i < 64; i++) begin
         d = $urandom;
         s = 1'($urandom_range(0, 1));
         do begin
            drive(1'b1, s, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
            guard++;
         end while (!acc && guard < 2000);
      end
      chk("stream_guard", {31'd0, guard >= 2000}, 32'd0);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
      chk("drain_a", qa.size(), 32'd0);
      chk("drain_b", qb.size(), 32'd0);

      // Both full, then asynchronous reset mid-cycle.
      drive(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0, acc);
      drive(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0, acc);
      drive(1'b1, 1'b1, 32'hB1, 1'b0, 1'b0, acc);
      drive(1'b1, 1'b1, 32'hB2, 1'b0, 1'b0, acc);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_a_valid", {31'd0, bus.a_valid}, 32'd0);
      chk("async_b_valid", {31'd0, bus.b_valid}, 32'd0);
      chk("async_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("async_a_data", bus.a_data, 32'h0);
      chk("async_b_data", bus.b_data, 32'h0);
      qa.delete();
      qb.delete();
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 32'hA1, 1'b1, 1'b1, acc);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1, acc);
      chk("post_rst_acc", {31'd0, acc}, 32'd1);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/demux1_2.md
# demux1_2

Registered 1-to-2 demultiplexer with valid/ready handshake: each 32-bit word presented on the input channel is steered to output channel A or B by `in_sel`. Each output channel has its own small FIFO, so a stalled consumer on one side does not block traffic to the other. It is the inverse of the datapath 2:1 mux, used where one producer (e.g. the ALU/writeback result) must feed two independently stalling consumers.

## Interface
- `WIDTH`, 32: data width, bits.
- `DEPTH`, 2: entries per output FIFO. Must be a power of two and at least 2.
- `clk`  in  1  sole clock. All state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word is valid.
- `in_ready`  out  1  input word is accepted this cycle.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  1  destination: 0 = A, 1 = B. Sampled with `in_data`.
- `a_valid`  out  1  head of FIFO A is valid.
- `a_ready`  in  1  consumer A takes the head.
- `a_data`  out  WIDTH  head of FIFO A.
- `b_valid`, `b_ready`, `b_data`: same as the A signals, for channel B.

## Operation
- Transfer rules:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer on X occurs when `x_valid && x_ready`.
- `in_ready`:
  - Forced 0 while `rst_n` = 0.
  - Otherwise `in_ready = !full_A` when `in_sel` = 0, and `!full_B` when `in_sel` = 1.
  - Combinational from `in_sel` and the registered occupancy only. It never depends on `a_ready` or `b_ready`.
- A full FIFO does not accept a push in the same cycle it pops. Space freed by a pop is visible on the next cycle.
- Each FIFO:
  - Write pointer, read pointer, and a count of width `$clog2(DEPTH)+1`. Pointers wrap modulo `DEPTH`.
  - `full` = (count == `DEPTH`); `empty` = (count == 0).
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- `x_valid = !empty_X`. `x_data` = entry at the read pointer, driven straight from storage (no output register stage).
- Ordering:
  - Words to the same channel leave in acceptance order.
  - There is no ordering relation between A and B.
- Storage contents are don't-care when empty. `x_data` is only meaningful while `x_valid` = 1.
- Data is never altered, duplicated, or dropped. A word goes to exactly one channel.
- Reset (async assert, any time including mid-transfer):
  - Pointers and counts go to 0; `a_valid` = `b_valid` = 0; `in_ready` = 0.
  - `a_data` = `b_data` = 0 (storage is cleared).
  - All in-flight contents are discarded.
  - After deassertion, `in_ready` rises in the same cycle for either `in_sel`.
- Input stability: once `in_valid` is asserted, the source keeps `in_data`/`in_sel` stable until accepted. The block does not check this.

## Timing
- Latency: a word accepted on rising edge N is visible on `x_valid`/`x_data` after edge N (cycle N+1), provided that FIFO was empty.
- Throughput: one word per cycle into either channel while the target FIFO is not full and its consumer drains at one word per cycle.
- Back-pressure:
  - With `x_ready` held 0, exactly `DEPTH` words are accepted for channel X.
  - `in_ready` then drops for `in_sel` = X but stays 1 for the other channel.
- Full FIFO, `x_ready` = 1 at edge N: pop at N, `in_ready` = 1 from cycle N+1.
- Channel switch: back-to-back words with alternating `in_sel` are accepted on consecutive cycles with no bubble.

## Test plan
- Reset then idle:
  - `rst_n` low for 3 cycles → `a_valid` = `b_valid` = 0, `in_ready` = 0, `a_data` = `b_data` = 0.
  - Release → `in_ready` = 1 on the next sampled cycle.
- Single routing:
  - Send 0xDEADBEEF with `in_sel` = 0, then 0x12345678 with `in_sel` = 1, both consumers ready.
  - Expect: `a_data` = 0xDEADBEEF one cycle after its accept; `b_data` = 0x12345678 one cycle after its accept; no word appears on the wrong channel.
- Fill and block:
  - `a_ready` = 0; offer 0x1, 0x2, 0x3 to A.
  - Expect 0x1 and 0x2 accepted, then `in_ready` = 0 for `in_sel` = 0.
  - Switch `in_sel` = 1 with 0x9 → accepted immediately.
  - Raise `a_ready` → A outputs 0x1 then 0x2; 0x3 accepted the cycle after the first pop.
- Simultaneous push/pop:
  - A holds 1 word; push 0x55 to A while `a_ready` = 1.
  - Expect count stays 1 and the sequence out is the old word then 0x55.
- Streaming/wrap:
  - 64 random words with random `in_sel`; random `a_ready`/`b_ready` at 50%.
  - A scoreboard checks per-channel order and content across many pointer wraps, with zero loss.
- Reset mid-operation:
  - Both FIFOs full; assert `rst_n` asynchronously mid-cycle.
  - Expect `a_valid`/`b_valid`/`in_ready` to go to 0 immediately, without waiting for a clock edge.
  - After release, the first word accepted is the first word output; no stale data appears.
